// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - commit-trace recorder with circular buffer, halt freeze and valid/ready drain
module pipeline_trace_buffer #(
    parameter int         XLEN        = 32,
    parameter int         DEPTH       = 16,
    parameter int         CNT_W       = 32,
    parameter logic [6:0] HALT_OPCODE = 7'b1111111
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       stop_on_full,
    input  logic [31:0]                if_instr,
    input  logic                       wb_valid,
    input  logic [XLEN-1:0]            wb_pc,
    input  logic [31:0]                wb_instr,
    input  logic [4:0]                 wb_rd,
    input  logic                       wb_reg_wr,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [XLEN-1:0]            rd_pc,
    output logic [31:0]                rd_instr,
    output logic [4:0]                 rd_rd,
    output logic [XLEN-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       halted,
    output logic                       overflow,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [CNT_W-1:0]           retired_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              halted_q, halted_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;

    // Trace storage; deliberately not reset, contents only meaningful while count != 0.
    logic [XLEN-1:0]   mem_pc   [DEPTH];
    logic [31:0]       mem_instr[DEPTH];
    logic [4:0]        mem_rd   [DEPTH];
    logic              mem_wr   [DEPTH];
    logic [XLEN-1:0]   mem_data [DEPTH];

    logic              wr_en;
    logic              is_full;
    logic              halt_hit;
    logic              accept;
    logic              pop;
    logic              unused_if_hi;

    // Only the opcode field of the fetched instruction matters for halt detection.
    assign unused_if_hi = ^if_instr[31:7];

    assign is_full  = (count_q == FULL_CNT);
    assign halt_hit = (if_instr[6:0] == HALT_OPCODE);
    // In stop mode a full buffer refuses commits; in wrap mode the oldest entry is replaced.
    assign accept   = wb_valid && !(is_full && stop_on_full);
    assign rd_valid = (state_q == ST_FROZEN) && (count_q != '0);
    assign pop      = rd_valid && rd_ready;

    // Next-state, pointer, counter and flag computation; clear wins over every other event.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        halted_d      = halted_q;
        overflow_d    = overflow_q;
        cycle_cnt_d   = cycle_cnt_q;
        retired_cnt_d = retired_cnt_q;
        wr_en         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (enable) begin
                    if (cycle_cnt_q != '1) begin
                        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    end
                    if (accept) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (retired_cnt_q != '1) begin
                            retired_cnt_d = retired_cnt_q + CNT_W'(1);
                        end
                        if (is_full) begin
                            rd_ptr_d   = rd_ptr_q + AW'(1);
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                    if (halt_hit) begin
                        halted_d = 1'b1;
                        state_d  = ST_FROZEN;
                    end else if (stop_on_full && (count_d == FULL_CNT)) begin
                        state_d = ST_FROZEN;
                    end
                end
            end
            ST_FROZEN: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear) begin
            state_d       = ST_IDLE;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            halted_d      = 1'b0;
            overflow_d    = 1'b0;
            cycle_cnt_d   = '0;
            retired_cnt_d = '0;
            wr_en         = 1'b0;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            halted_q      <= 1'b0;
            overflow_q    <= 1'b0;
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            halted_q      <= halted_d;
            overflow_q    <= overflow_d;
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // Commit write into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr_q]    <= wb_pc;
            mem_instr[wr_ptr_q] <= wb_instr;
            mem_rd[wr_ptr_q]    <= wb_rd;
            mem_wr[wr_ptr_q]    <= wb_reg_wr;
            mem_data[wr_ptr_q]  <= wb_data;
        end
    end

    // Oldest entry presented combinationally; rd/data masked for commits that wrote no register.
    always_comb begin
        rd_pc    = mem_pc[rd_ptr_q];
        rd_instr = mem_instr[rd_ptr_q];
        rd_rd    = mem_wr[rd_ptr_q] ? mem_rd[rd_ptr_q]   : 5'd0;
        rd_data  = mem_wr[rd_ptr_q] ? mem_data[rd_ptr_q] : '0;
    end

    assign count       = count_q;
    assign halted      = halted_q;
    assign overflow    = overflow_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb/tb_pipeline_trace_buffer.sv - directed scoreboard bench for pipeline_trace_buffer
module tb_pipeline_trace_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, clear, stop_on_full;
    logic [31:0] if_instr;
    logic        wb_valid;
    logic [31:0] wb_pc, wb_instr, wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_wr;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_pc, rd_instr, rd_data;
    logic [4:0]  rd_rd;
    logic [2:0]  count;
    logic        halted, overflow;
    logic [31:0] cycle_cnt, retired_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t sb[$];
    logic model_stop;
    int   total = 0;
    int   bad   = 0;

    pipeline_trace_buffer #(
        .XLEN(32), .DEPTH(DEPTH), .CNT_W(32), .HALT_OPCODE(7'b1111111)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .stop_on_full(stop_on_full),
        .if_instr(if_instr), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .wb_data(wb_data), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_rd(rd_rd),
        .rd_data(rd_data), .count(count), .halted(halted), .overflow(overflow),
        .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                          input logic wr, input logic [31:0] data, input logic with_halt);
        ent_t e;
        wb_valid  = 1'b1;
        wb_pc     = pc;
        wb_instr  = instr;
        wb_rd     = rd;
        wb_reg_wr = wr;
        wb_data   = data;
        if (with_halt) if_instr = HALT;
        e.pc    = pc;
        e.instr = instr;
        e.rd    = wr ? rd : 5'd0;
        e.data  = wr ? data : 32'd0;
        if (sb.size() == DEPTH) begin
            if (!model_stop) begin
                void'(sb.pop_front());
                sb.push_back(e);
            end
        end else begin
            sb.push_back(e);
        end
        tick();
        wb_valid = 1'b0;
        if_instr = NOP;
    endtask

    task automatic pop_chk(input string tag);
        ent_t e;
        chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"},    64'(rd_pc),    64'(e.pc));
            chk({tag, "_instr"}, 64'(rd_instr), 64'(e.instr));
            chk({tag, "_rd"},    64'(rd_rd),    64'(e.rd));
            chk({tag, "_data"},  64'(rd_data),  64'(e.data));
        end
    endtask

    task automatic do_clear();
        enable = 1'b0;
        clear  = 1'b1;
        tick();
        clear = 1'b0;
        sb.delete();
    endtask

    task automatic start();
        enable = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; clear = 1'b0; stop_on_full = 1'b0;
        if_instr = NOP; wb_valid = 1'b0; wb_pc = '0; wb_instr = '0; wb_rd = '0;
        wb_reg_wr = 1'b0; wb_data = '0; rd_ready = 1'b0; model_stop = 1'b0;
        #12;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_cycle", 64'(cycle_cnt), 64'd0);
        chk("rst_retired", 64'(retired_cnt), 64'd0);
        rst = 1'b1;
        tick();

        // wrap mode: 6 commits into 4 slots, then halt
        start();
        chk("t1_idle_to_capture_cycle", 64'(cycle_cnt), 64'd0);
        for (int i = 0; i < 6; i++) commit(32'(i * 4), 32'h0000_0093 + 32'(i << 7), 5'(i + 1), 1'b1, 32'(100 + i), 1'b0);
        if_instr = HALT;
        tick();
        if_instr = NOP;
        chk("t1_halted", 64'(halted), 64'd1);
        chk("t1_overflow", 64'(overflow), 64'd1);
        chk("t1_retired", 64'(retired_cnt), 64'd6);
        chk("t1_count", 64'(count), 64'd4);
        chk("t1_cycle", 64'(cycle_cnt), 64'd7);
        tick();
        chk("t1_cycle_hold", 64'(cycle_cnt), 64'd7);
        for (int i = 0; i < 4; i++) begin
            pop_chk("t1_drain");
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        chk("t1_empty_valid", 64'(rd_valid), 64'd0);
        chk("t1_empty_count", 64'(count), 64'd0);

        do_clear();
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_halted", 64'(halted), 64'd0);
        chk("clr_overflow", 64'(overflow), 64'd0);
        chk("clr_cycle", 64'(cycle_cnt), 64'd0);
        chk("clr_retired", 64'(retired_cnt), 64'd0);

        // stop mode: fifth back-to-back commit dropped
        stop_on_full = 1'b1;
        model_stop   = 1'b1;
        start();
        for (int i = 0; i < 5; i++) commit(32'h100 + 32'(i * 4), 32'h0000_0113, 5'd2, 1'b1, 32'(i), 1'b0);
        chk("t2_count", 64'(count), 64'd4);
        chk("t2_retired", 64'(retired_cnt), 64'd4);
        chk("t2_cycle", 64'(cycle_cnt), 64'd4);
        chk("t2_halted", 64'(halted), 64'd0);
        chk("t2_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            pop_chk("t2_drain");
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        chk("t2_empty_valid", 64'(rd_valid), 64'd0);

        // store masking, halt with same-cycle commit, toggled drain
        do_clear();
        stop_on_full = 1'b0;
        model_stop   = 1'b0;
        start();
        enable = 1'b0;
        tick();
        chk("t3_enable_low_hold", 64'(cycle_cnt), 64'd0);
        enable = 1'b1;
        commit(32'h40, 32'h0071_2023, 5'd7, 1'b0, 32'hDEAD, 1'b0);
        commit(32'h30, 32'h0030_0193, 5'd3, 1'b1, 32'h33, 1'b0);
        commit(32'h20, 32'h02A0_0293, 5'd5, 1'b1, 32'd42, 1'b1);
        chk("t3_halted", 64'(halted), 64'd1);
        chk("t3_count", 64'(count), 64'd3);
        chk("t3_cycle", 64'(cycle_cnt), 64'd3);
        tick();
        tick();
        chk("t3_cycle_frozen", 64'(cycle_cnt), 64'd3);
        pop_chk("t3_pop1");
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        tick();
        chk("t3_stall_count", 64'(count), 64'd2);
        chk("t3_stall_valid", 64'(rd_valid), 64'd1);
        pop_chk("t3_pop2");
        rd_ready = 1'b1;
        tick();
        pop_chk("t3_pop3");
        tick();
        chk("t3_after_valid", 64'(rd_valid), 64'd0);
        chk("t3_after_count", 64'(count), 64'd0);
        tick();
        rd_ready = 1'b0;
        chk("t3_ready_noop_count", 64'(count), 64'd0);
        chk("t3_ready_noop_valid", 64'(rd_valid), 64'd0);

        // async reset during drain
        do_clear();
        start();
        for (int i = 0; i < 3; i++) commit(32'h200 + 32'(i * 4), 32'h0000_0213, 5'd4, 1'b1, 32'(i), 1'b0);
        if_instr = HALT;
        tick();
        if_instr = NOP;
        pop_chk("t4_pop1");
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t4_before_rst_count", 64'(count), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("t4_rst_valid", 64'(rd_valid), 64'd0);
        chk("t4_rst_count", 64'(count), 64'd0);
        sb.delete();
        #2;
        rst = 1'b1;
        tick();
        chk("t4_idle_cycle", 64'(cycle_cnt), 64'd0);
        chk("t4_idle_retired", 64'(retired_cnt), 64'd0);
        chk("t4_idle_halted", 64'(halted), 64'd0);
        tick();
        chk("t4_capture_cycle", 64'(cycle_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_trace_buffer.md
Name: pipeline_trace_buffer

Overview:
Synthesizable commit-trace recorder for the RV32I pipeline. It captures every retired writeback (PC, instruction, rd, write data) into a parametrised circular buffer and keeps cycle and retire counters. It detects the halt opcode in the fetched instruction and then freezes. A valid/ready drain port lets a bench or debug host read the trace oldest-first. It sits beside the core, tapping the MEM/WB boundary and the IF output.

Parameters:
XLEN, 32, data/PC width
DEPTH, 16, trace entries (power of two, >=2)
CNT_W, 32, width of cycle/retire counters
HALT_OPCODE, 7'b1111111, opcode that ends capture

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
enable  in  1  core-running qualifier; capture and counting only when high
clear  in  1  synchronous clear to IDLE; empties buffer, zeroes counters and flags
stop_on_full  in  1  mode: 0 = wrap (keep last DEPTH), 1 = freeze when full
if_instr  in  32  instruction at IF output; halt detect
wb_valid  in  1  a commit is present at MEM/WB this cycle
wb_pc  in  XLEN  PC of committing instruction
wb_instr  in  32  committing instruction
wb_rd  in  5  destination register
wb_reg_wr  in  1  register write enable of the commit
wb_data  in  XLEN  value written back
rd_ready  in  1  drain consumer ready
rd_valid  out  1  drain entry valid
rd_pc  out  XLEN  drained PC
rd_instr  out  32  drained instruction
rd_rd  out  5  drained rd; forced 0 when the entry had reg_wr=0
rd_data  out  XLEN  drained data; forced 0 when reg_wr=0
count  out  $clog2(DEPTH)+1  entries held
halted  out  1  halt opcode seen (sticky)
overflow  out  1  at least one entry overwritten in wrap mode (sticky)
cycle_cnt  out  CNT_W  cycles spent in CAPTURE
retired_cnt  out  CNT_W  commits accepted

Behaviour:
- Reset (rst=0, async): state=IDLE; wr_ptr=rd_ptr=0; count=0; halted=overflow=0; cycle_cnt=retired_cnt=0; rd_valid=0. Buffer RAM is not cleared; its contents are don't-care.
- States: IDLE, CAPTURE, FROZEN.
- IDLE -> CAPTURE on the first cycle with enable=1. Nothing is captured in that transition cycle.
- CAPTURE, enable=1:
  - cycle_cnt+1 per cycle, saturating at all-ones.
  - wb_valid=1 writes {pc, instr, rd, reg_wr, data} at wr_ptr; wr_ptr+1 mod DEPTH; retired_cnt+1, saturating.
- CAPTURE, enable=0: hold all state, no capture.
- Full (count=DEPTH) with commit:
  - Wrap mode: overwrite the oldest entry; rd_ptr+1; count stays DEPTH; overflow<=1.
  - Stop mode: unreachable, because the commit that makes count=DEPTH moves to FROZEN in the next cycle.
- Halt: if_instr[6:0]==HALT_OPCODE in CAPTURE with enable=1 sets halted=1 and moves to FROZEN next cycle. A wb_valid commit in the same cycle is still captured.
- Halt and fill in the same cycle: FROZEN, with halted=1.
- FROZEN:
  - No capture; counters hold.
  - rd_valid = (count!=0). rd_* present the entry at rd_ptr combinationally.
  - rd_valid & rd_ready pops: rd_ptr+1, count-1. One pop per cycle; zero-latency next entry.
  - rd_ready asserted while rd_valid=0 has no effect.
  - At count=0, stay FROZEN until clear.
- rd_valid is 0 in IDLE and CAPTURE.
- clear: overrides all other events in any state; returns to IDLE with reset values; takes effect next edge.
- Async reset mid-drain: rd_valid drops immediately and the trace is lost.

Test Plan:
- DEPTH=4, stop_on_full=0: 6 commits at PCs 0x00,0x04..0x14, then halt -> drain yields PCs 0x08,0x0C,0x10,0x14 in order; overflow=1, retired_cnt=6, halted=1.
- DEPTH=4, stop_on_full=1: 5 commits back-to-back -> count=4, FROZEN, 5th commit dropped (retired_cnt=4), halted=0, drain yields first 4 PCs.
- Halt opcode and wb_valid (PC 0x20, rd=5, data=42) in same cycle -> entry captured; after FROZEN, cycle_cnt stops incrementing; drained entry shows rd=5, data=42.
- Commit with wb_reg_wr=0 (store, rd field=7) -> drained rd_rd=0, rd_data=0, rd_pc correct.
- Drain with rd_ready toggling 1,0,1,1 over 3 entries -> exactly 3 pops; rd_valid falls the cycle after the third pop; count=0.
- Async rst low mid-drain (2 entries left) -> rd_valid=0 and count=0 immediately; after release plus enable, state is IDLE then CAPTURE with counters at 0.
